// File: rtl/zap_tag_ram_nway.sv
// Set-associative tag store with per-entry valid bits, round-robin victim pointers
// and a registered, write-first lookup of one set per cycle.
module zap_tag_ram_nway #(
   parameter int DEPTH = 32,
   parameter int WAYS  = 4,
   parameter int WIDTH = 20,
   localparam int AW   = $clog2(DEPTH),
   localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_rd_en,
   input  logic [AW-1:0]         i_raddr,
   input  logic [WIDTH-1:0]      i_rtag,
   input  logic                  i_wen,
   input  logic [AW-1:0]         i_waddr,
   input  logic [WW-1:0]         i_wway,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic                  i_inv_one,
   input  logic [AW-1:0]         i_inv_addr,
   input  logic [WW-1:0]         i_inv_way,
   input  logic                  i_inv_all,
   output logic [WAYS*WIDTH-1:0] o_rdata,
   output logic [WAYS-1:0]       o_rvalid,
   output logic [WAYS-1:0]       o_hit_way,
   output logic                  o_hit,
   output logic [WW-1:0]         o_victim,
   output logic                  o_rdav
);

   logic [WIDTH-1:0]            tag_mem [DEPTH][WAYS];
   logic [DEPTH-1:0][WAYS-1:0]  valid_q, valid_nxt;
   logic [DEPTH-1:0][WW-1:0]    rr_q, rr_nxt;

   logic [WIDTH-1:0]      tag_rd [WAYS];
   logic [WAYS-1:0]       valid_rd;
   logic [WW-1:0]         rr_rd;
   logic [WAYS*WIDTH-1:0] rdata_d;
   logic [WAYS-1:0]       hit_way_d;
   logic [WW-1:0]         victim_d;
   logic                  found;

   // Next-state of valids and pointers; inv_one beats wen on a shared entry, inv_all beats all.
   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         valid_nxt[s] = valid_q[s];
         rr_nxt[s]    = rr_q[s];
         if (i_wen && (i_waddr == AW'(s))) begin
            rr_nxt[s] = (WAYS > 1) ? rr_q[s] + WW'(1) : '0;
            for (int w = 0; w < WAYS; w++)
               if (i_wway == WW'(w)) valid_nxt[s][w] = 1'b1;
         end
         if (i_inv_one && (i_inv_addr == AW'(s))) begin
            for (int w = 0; w < WAYS; w++)
               if (i_inv_way == WW'(w)) valid_nxt[s][w] = 1'b0;
         end
         if (i_inv_all) begin
            valid_nxt[s] = '0;
            rr_nxt[s]    = '0;
         end
      end
   end

   always_comb begin
      valid_rd  = valid_nxt[i_raddr];
      rr_rd     = rr_nxt[i_raddr];
      rdata_d   = '0;
      hit_way_d = '0;
      victim_d  = rr_rd;
      found     = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         tag_rd[w] = tag_mem[i_raddr][w];
         if (i_wen && (i_waddr == i_raddr) && (i_wway == WW'(w)))
            tag_rd[w] = i_wdata;
         rdata_d[w*WIDTH +: WIDTH] = tag_rd[w];
         hit_way_d[w] = valid_rd[w] && (tag_rd[w] == i_rtag);
         if (!found && !valid_rd[w]) begin
            victim_d = WW'(w);
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wen) begin
         for (int w = 0; w < WAYS; w++)
            if (i_wway == WW'(w)) tag_mem[i_waddr][w] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else begin
         valid_q <= valid_nxt;
         rr_q    <= rr_nxt;
      end
   end

   // Outputs hold between lookups, except that inv_all drops the reported valids and hits.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rdata   <= '0;
         o_rvalid  <= '0;
         o_hit_way <= '0;
         o_hit     <= 1'b0;
         o_victim  <= '0;
         o_rdav    <= 1'b0;
      end else begin
         o_rdav <= i_rd_en;
         if (i_rd_en) begin
            o_rdata   <= rdata_d;
            o_rvalid  <= valid_rd;
            o_hit_way <= hit_way_d;
            o_hit     <= |hit_way_d;
            o_victim  <= victim_d;
         end else if (i_inv_all) begin
            o_rvalid  <= '0;
            o_hit_way <= '0;
            o_hit     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_zap_tag_ram_nway.sv
// Directed self-checking bench for zap_tag_ram_nway (DEPTH=32, WAYS=4, WIDTH=20).
module tb_zap_tag_ram_nway;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_rd_en;
   logic [4:0]  i_raddr;
   logic [19:0] i_rtag;
   logic        i_wen;
   logic [4:0]  i_waddr;
   logic [1:0]  i_wway;
   logic [19:0] i_wdata;
   logic        i_inv_one;
   logic [4:0]  i_inv_addr;
   logic [1:0]  i_inv_way;
   logic        i_inv_all;
   logic [79:0] o_rdata;
   logic [3:0]  o_rvalid;
   logic [3:0]  o_hit_way;
   logic        o_hit;
   logic [1:0]  o_victim;
   logic        o_rdav;

   int checks = 0;
   int passed = 0;

   zap_tag_ram_nway #(.DEPTH(32), .WAYS(4), .WIDTH(20)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rd_en(i_rd_en), .i_raddr(i_raddr),
      .i_rtag(i_rtag), .i_wen(i_wen), .i_waddr(i_waddr), .i_wway(i_wway),
      .i_wdata(i_wdata), .i_inv_one(i_inv_one), .i_inv_addr(i_inv_addr),
      .i_inv_way(i_inv_way), .i_inv_all(i_inv_all), .o_rdata(o_rdata),
      .o_rvalid(o_rvalid), .o_hit_way(o_hit_way), .o_hit(o_hit),
      .o_victim(o_victim), .o_rdav(o_rdav)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_rd_en = 0; i_raddr = '0; i_rtag = '0;
      i_wen = 0; i_waddr = '0; i_wway = '0; i_wdata = '0;
      i_inv_one = 0; i_inv_addr = '0; i_inv_way = '0; i_inv_all = 0;
   endtask

   task automatic write(input logic [4:0] s, input logic [1:0] w, input logic [19:0] t);
      i_wen = 1; i_waddr = s; i_wway = w; i_wdata = t;
      tick();
      i_wen = 0;
   endtask

   task automatic lookup(input logic [4:0] s, input logic [19:0] t);
      i_rd_en = 1; i_raddr = s; i_rtag = t;
      tick();
      i_rd_en = 0;
   endtask

   task automatic test_reset();
      i_reset_n = 0;
      idle();
      #3;
      checks++; if ({o_rdata, o_rvalid, o_hit_way, o_hit, o_victim, o_rdav} !== '0)
         $display("FAIL reset_initial outputs got %h want 0", {o_rdata, o_rvalid, o_hit_way, o_hit, o_victim, o_rdav}); else passed++;
      tick(); tick();
      i_reset_n = 1;
      lookup(5'd5, 20'h0);
      checks++; if (o_rdav !== 1'b1) $display("FAIL reset_lookup rdav got %b want 1", o_rdav); else passed++;
      checks++; if (o_rvalid !== 4'b0000) $display("FAIL reset_lookup rvalid got %b want 0000", o_rvalid); else passed++;
      checks++; if (o_hit !== 1'b0) $display("FAIL reset_lookup hit got %b want 0", o_hit); else passed++;
      checks++; if (o_victim !== 2'd0) $display("FAIL reset_lookup victim got %0d want 0", o_victim); else passed++;
      // request outstanding, then reset between edges
      i_rd_en = 1; i_raddr = 5'd5;
      #2;
      i_reset_n = 0;
      #1;
      checks++; if ({o_rdata, o_rvalid, o_hit_way, o_hit, o_victim, o_rdav} !== '0)
         $display("FAIL reset_async outputs got %h want 0", {o_rdata, o_rvalid, o_hit_way, o_hit, o_victim, o_rdav}); else passed++;
      i_rd_en = 0;
      tick();
      i_reset_n = 1;
      tick();
      checks++; if (o_rdav !== 1'b0) $display("FAIL reset_no_pulse rdav got %b want 0", o_rdav); else passed++;
   endtask

   task automatic test_fill_hit();
      write(5'd3, 2'd0, 20'h11);
      write(5'd3, 2'd1, 20'h22);
      write(5'd3, 2'd2, 20'h33);
      write(5'd3, 2'd3, 20'h44);
      lookup(5'd3, 20'h33);
      checks++; if (o_rvalid !== 4'b1111) $display("FAIL fill_rvalid got %b want 1111", o_rvalid); else passed++;
      checks++; if (o_hit_way !== 4'b0100) $display("FAIL fill_hit_way got %b want 0100", o_hit_way); else passed++;
      checks++; if (o_hit !== 1'b1) $display("FAIL fill_hit got %b want 1", o_hit); else passed++;
      checks++; if (o_victim !== 2'd0) $display("FAIL fill_victim got %0d want 0", o_victim); else passed++;
      checks++; if (o_rdav !== 1'b1) $display("FAIL fill_rdav got %b want 1", o_rdav); else passed++;
      checks++; if (o_rdata !== {20'h44, 20'h33, 20'h22, 20'h11})
         $display("FAIL fill_rdata got %h want %h", o_rdata, {20'h44, 20'h33, 20'h22, 20'h11}); else passed++;
   endtask

   task automatic test_victim();
      i_inv_one = 1; i_inv_addr = 5'd3; i_inv_way = 2'd2;
      tick();
      i_inv_one = 0;
      lookup(5'd3, 20'h33);
      checks++; if (o_victim !== 2'd2) $display("FAIL victim_inv victim got %0d want 2", o_victim); else passed++;
      checks++; if (o_rvalid !== 4'b1011) $display("FAIL victim_inv rvalid got %b want 1011", o_rvalid); else passed++;
      checks++; if (o_hit !== 1'b0) $display("FAIL victim_inv hit got %b want 0", o_hit); else passed++;
      // write to way 1 and look up on the same edge
      i_wen = 1; i_waddr = 5'd3; i_wway = 2'd1; i_wdata = 20'h55;
      lookup(5'd3, 20'h55);
      i_wen = 0;
      checks++; if (o_victim !== 2'd2) $display("FAIL victim_after_write victim got %0d want 2", o_victim); else passed++;
      checks++; if (o_hit_way !== 4'b0010) $display("FAIL victim_after_write hit_way got %b want 0010", o_hit_way); else passed++;
   endtask

   task automatic test_bypass();
      i_wen = 1; i_waddr = 5'd7; i_wway = 2'd1; i_wdata = 20'hABC;
      lookup(5'd7, 20'hABC);
      i_wen = 0;
      checks++; if (o_hit_way !== 4'b0010) $display("FAIL bypass_hit_way got %b want 0010", o_hit_way); else passed++;
      checks++; if (o_hit !== 1'b1) $display("FAIL bypass_hit got %b want 1", o_hit); else passed++;
      checks++; if (o_victim !== 2'd0) $display("FAIL bypass_victim got %0d want 0", o_victim); else passed++;
      checks++; if (o_rvalid !== 4'b0010) $display("FAIL bypass_rvalid got %b want 0010", o_rvalid); else passed++;
      checks++; if (o_rdata[20 +: 20] !== 20'hABC) $display("FAIL bypass_tag got %h want abc", o_rdata[20 +: 20]); else passed++;
   endtask

   task automatic test_priority();
      i_wen = 1; i_waddr = 5'd2; i_wway = 2'd0; i_wdata = 20'h777;
      i_inv_one = 1; i_inv_addr = 5'd2; i_inv_way = 2'd0;
      lookup(5'd2, 20'h777);
      i_wen = 0; i_inv_one = 0;
      checks++; if (o_rvalid !== 4'b0000) $display("FAIL prio_one rvalid got %b want 0000", o_rvalid); else passed++;
      checks++; if (o_hit !== 1'b0) $display("FAIL prio_one hit got %b want 0", o_hit); else passed++;
      checks++; if (o_rdata[19:0] !== 20'h777) $display("FAIL prio_one tag got %h want 777", o_rdata[19:0]); else passed++;
      lookup(5'd2, 20'h777);
      checks++; if (o_rvalid !== 4'b0000) $display("FAIL prio_one_later rvalid got %b want 0000", o_rvalid); else passed++;
      // five writes leave set 1's pointer at 1; the write below would take it to 2
      for (int w = 0; w < 4; w++) write(5'd1, 2'(w), 20'hA0 + 20'(w));
      write(5'd1, 2'd0, 20'hA0);
      i_wen = 1; i_waddr = 5'd1; i_wway = 2'd2; i_wdata = 20'hA2;
      i_inv_all = 1;
      lookup(5'd1, 20'hA2);
      i_wen = 0; i_inv_all = 0;
      checks++; if (o_rvalid !== 4'b0000) $display("FAIL prio_all rvalid got %b want 0000", o_rvalid); else passed++;
      checks++; if (o_hit !== 1'b0) $display("FAIL prio_all hit got %b want 0", o_hit); else passed++;
      checks++; if (o_victim !== 2'd0) $display("FAIL prio_all victim got %0d want 0", o_victim); else passed++;
      lookup(5'd3, 20'h11);
      checks++; if (o_rvalid !== 4'b0000) $display("FAIL prio_all_set3 rvalid got %b want 0000", o_rvalid); else passed++;
      for (int w = 0; w < 4; w++) write(5'd1, 2'(w), 20'hA0 + 20'(w));
      lookup(5'd1, 20'hA2);
      checks++; if (o_rvalid !== 4'b1111) $display("FAIL prio_refill rvalid got %b want 1111", o_rvalid); else passed++;
      checks++; if (o_hit_way !== 4'b0100) $display("FAIL prio_refill hit_way got %b want 0100", o_hit_way); else passed++;
      checks++; if (o_victim !== 2'd0) $display("FAIL prio_refill victim got %0d want 0", o_victim); else passed++;
   endtask

   task automatic test_hold_clear();
      logic [79:0] exp_data;
      exp_data = {20'hA3, 20'hA2, 20'hA1, 20'hA0};
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (o_rdav !== 1'b0) $display("FAIL hold_rdav cycle %0d got %b want 0", c, o_rdav); else passed++;
         checks++; if (o_hit !== 1'b1 || o_hit_way !== 4'b0100)
            $display("FAIL hold_hit cycle %0d got %b/%b want 1/0100", c, o_hit, o_hit_way); else passed++;
         checks++; if (o_rdata !== exp_data) $display("FAIL hold_rdata cycle %0d got %h want %h", c, o_rdata, exp_data); else passed++;
      end
      i_inv_all = 1;
      tick();
      i_inv_all = 0;
      checks++; if (o_hit !== 1'b0) $display("FAIL clear_hit got %b want 0", o_hit); else passed++;
      checks++; if (o_rvalid !== 4'b0000) $display("FAIL clear_rvalid got %b want 0000", o_rvalid); else passed++;
      checks++; if (o_hit_way !== 4'b0000) $display("FAIL clear_hit_way got %b want 0000", o_hit_way); else passed++;
      checks++; if (o_rdata !== exp_data) $display("FAIL clear_rdata got %h want %h", o_rdata, exp_data); else passed++;
      checks++; if (o_rdav !== 1'b0) $display("FAIL clear_rdav got %b want 0", o_rdav); else passed++;
   endtask

   initial begin
      test_reset();
      test_fill_hit();
      test_victim();
      test_bypass();
      test_priority();
      test_hold_clear();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
